// File: rtl/spi_sp_ram_if.sv
// Command/response bundle between the SPI slave and spi_sp_ram.
// The SPI slave drives din/rx_valid; the RAM returns dout/tx_valid and seq_err.
interface spi_sp_ram_if;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;
   logic       seq_err;

   modport master (output din, rx_valid, input dout, tx_valid, seq_err);
   modport slave  (input din, rx_valid, output dout, tx_valid, seq_err);
endinterface

// File: rtl/spi_sp_ram.sv
// Single-port RAM with a 10-bit command decoder and auto-incrementing read/write pointers.
// Optional SEQ_CHECK_EN macro: drops data commands issued before their address and pulses seq_err.
module spi_sp_ram #(
   parameter int ADDR_SIZE = 8
) (
   input  logic           clk,
   input  logic           rst,
   spi_sp_ram_if.slave    bus
);
   localparam int DEPTH = 2 ** ADDR_SIZE;
   localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } op_t;

   typedef enum logic {
      ST_IDLE,
      ST_TX
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [7:0]           r_mem [DEPTH];
   logic [ADDR_SIZE-1:0] r_wr_ptr;
   logic [ADDR_SIZE-1:0] r_rd_ptr;
   logic [7:0]           r_dout;
   logic                 r_seq_err;
   op_t                  w_op;
   logic                 w_illegal;
   logic                 w_accept;
   logic                 w_wr_addr;
   logic                 w_wr_data;
   logic                 w_rd_addr;
   logic                 w_rd_data;

`ifdef SEQ_CHECK_EN
   logic r_wr_ok;
   logic r_rd_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ok <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         if (w_wr_addr) r_wr_ok <= 1'b1;
         if (w_rd_addr) r_rd_ok <= 1'b1;
      end
   end
`endif

   always_comb begin
      w_op = op_t'(bus.din[9:8]);
`ifdef SEQ_CHECK_EN
      w_illegal = bus.rx_valid &&
                  (((w_op == OP_WR_DATA) && !r_wr_ok) ||
                   ((w_op == OP_RD_DATA) && !r_rd_ok));
`else
      w_illegal = 1'b0;
`endif
      w_accept  = bus.rx_valid && !w_illegal;
      w_wr_addr = w_accept && (w_op == OP_WR_ADDR);
      w_wr_data = w_accept && (w_op == OP_WR_DATA);
      w_rd_addr = w_accept && (w_op == OP_RD_ADDR);
      w_rd_data = w_accept && (w_op == OP_RD_DATA);
   end

   // Any accepted non-read word ends the transmit phase; dropped words leave it untouched
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = w_rd_data ? ST_TX : ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_dout    <= '0;
         r_seq_err <= 1'b0;
      end else begin
         r_seq_err <= w_illegal;
         if (w_wr_addr) r_wr_ptr <= bus.din[ADDR_SIZE-1:0];
         if (w_wr_data) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_addr) r_rd_ptr <= bus.din[ADDR_SIZE-1:0];
         if (w_rd_data) begin
            r_dout   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is never cleared so contents survive reset; reset still blocks a write
   always_ff @(posedge clk) begin
      if (!rst && w_wr_data) r_mem[r_wr_ptr] <= bus.din[7:0];
   end

   assign bus.dout     = r_dout;
   assign bus.tx_valid = (r_state == ST_TX);
   assign bus.seq_err  = r_seq_err;
endmodule

// File: tb/tb_spi_sp_ram.sv
// Self-checking bench for spi_sp_ram: directed table, hand-written corner sequences and
// randomized words, all compared against a word-level reference model.
module tb_spi_sp_ram;
   localparam int AW    = 8;
   localparam int DEPTH = 2 ** AW;

   logic clk;
   logic rst;
   spi_sp_ram_if bus ();

   spi_sp_ram #(.ADDR_SIZE(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] m_mem [DEPTH];
   int         m_wp, m_rp;
   bit         m_wok, m_rok;
   logic [7:0] m_dout;
   logic       m_tx, m_err;

   typedef struct {
      logic       rst;
      logic       v;
      logic [9:0] w;
      logic [7:0] exp_dout;
      logic       exp_tx;
      logic       exp_err;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic v, input logic [9:0] w);
      bit illegal;
      if (r) begin
         m_dout = 8'h00; m_tx = 1'b0; m_err = 1'b0;
         m_wp = 0; m_rp = 0; m_wok = 0; m_rok = 0;
      end else begin
         m_err = 1'b0;
         if (v) begin
            illegal = 0;
`ifdef SEQ_CHECK_EN
            illegal = (w[9:8] == 2'b01 && !m_wok) || (w[9:8] == 2'b11 && !m_rok);
`endif
            if (illegal) begin
               m_err = 1'b1;
            end else begin
               case (w[9:8])
                  2'b00: begin m_wp = int'(w[7:0]) % DEPTH; m_wok = 1; m_tx = 1'b0; end
                  2'b01: begin m_mem[m_wp] = w[7:0]; m_wp = (m_wp + 1) % DEPTH; m_tx = 1'b0; end
                  2'b10: begin m_rp = int'(w[7:0]) % DEPTH; m_rok = 1; m_tx = 1'b0; end
                  default: begin m_dout = m_mem[m_rp]; m_tx = 1'b1; m_rp = (m_rp + 1) % DEPTH; end
               endcase
            end
         end
      end
   endtask

   // One clock: drive on negedge, model the sampling edge, compare 1 time unit later
   task automatic step(input logic r, input logic v, input logic [9:0] w);
      @(negedge clk);
      rst = r;
      bus.rx_valid = v;
      bus.din = w;
      @(posedge clk);
      model_update(r, v, w);
      #1;
      chk("model_dout", bus.dout, m_dout);
      chk("model_tx_valid", {7'd0, bus.tx_valid}, {7'd0, m_tx});
      chk("model_seq_err", {7'd0, bus.seq_err}, {7'd0, m_err});
   endtask

   task automatic word(input logic [1:0] op, input logic [7:0] pl);
      step(1'b0, 1'b1, {op, pl});
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 10'h000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_wp = 0; m_rp = 0; m_wok = 0; m_rok = 0;
      m_dout = 8'h00; m_tx = 1'b0; m_err = 1'b0;
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.din = 10'h000;

      // Reset then write/read of 0xA5 at 0x10
      vecs.push_back('{1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 10'h3FF, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'h010, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'h1A5, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'h210, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'h300, 8'hA5, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 10'h000, 8'hA5, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 10'h3FF, 8'hA5, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'h020, 8'hA5, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 10'h000, 8'hA5, 1'b0, 1'b0});
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].v, vecs[i].w);
         chk($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_tx_valid", i), {7'd0, bus.tx_valid}, {7'd0, vecs[i].exp_tx});
         chk($sformatf("vec%0d_seq_err", i), {7'd0, bus.seq_err}, {7'd0, vecs[i].exp_err});
      end

      // Fill the whole RAM so every later read has a known value
      word(2'b00, 8'h00);
      for (int i = 0; i < DEPTH; i++) word(2'b01, 8'(i) ^ 8'h5A);

      // Burst with pointer wrap at the top address
      word(2'b00, 8'hFF); word(2'b01, 8'h11); word(2'b01, 8'h22);
      word(2'b10, 8'hFF);
      word(2'b11, 8'h00); chk("wrap_rd0", bus.dout, 8'h11);
      word(2'b11, 8'h00); chk("wrap_rd1", bus.dout, 8'h22);
      chk("wrap_tx", {7'd0, bus.tx_valid}, 8'd1);
      word(2'b10, 8'h00); chk("wrap_tx_drop", {7'd0, bus.tx_valid}, 8'd0);
      word(2'b11, 8'h00); chk("loc0", bus.dout, 8'h22);

      // Back-to-back words, read-after-write
      word(2'b00, 8'h40); word(2'b01, 8'h77); word(2'b10, 8'h40); word(2'b11, 8'h00);
      chk("b2b_dout", bus.dout, 8'h77);
      chk("b2b_tx", {7'd0, bus.tx_valid}, 8'd1);
      idle(); chk("b2b_hold", bus.dout, 8'h77);

      // Reset mid-operation keeps RAM contents
      word(2'b00, 8'h05); word(2'b01, 8'h3C);
      step(1'b1, 1'b1, 10'h1EE);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_tx", {7'd0, bus.tx_valid}, 8'd0);
      word(2'b10, 8'h05); word(2'b11, 8'h00);
      chk("rst_keep", bus.dout, 8'h3C);

      // Data read straight after reset
      step(1'b1, 1'b0, 10'h000);
      word(2'b11, 8'h00);
`ifdef SEQ_CHECK_EN
      chk("seq_err_pulse", {7'd0, bus.seq_err}, 8'd1);
      chk("seq_tx_low", {7'd0, bus.tx_valid}, 8'd0);
      idle();
      chk("seq_err_clear", {7'd0, bus.seq_err}, 8'd0);
`else
      chk("nochk_dout", bus.dout, 8'h22);
      chk("nochk_tx", {7'd0, bus.tx_valid}, 8'd1);
      chk("nochk_err", {7'd0, bus.seq_err}, 8'd0);
`endif

      // Randomized words, rare resets, idle gaps
      for (int n = 0; n < 1500; n++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), 10'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
